// File: rtl/note_scroller_if.sv
// Bus bundle between the note scroller and its environment: run control, note/button inputs,
// the visible field and the judgement pulses/counters.
interface note_scroller_if #(
  parameter int LANES = 4,
  parameter int ROWS  = 10,
  parameter int CNT_W = 16
);
  logic                     start;
  logic [1:0]               speed;
  logic [LANES-1:0]         data;
  logic [LANES-1:0]         buttons;
  logic [LANES*ROWS-1:0]    out;
  logic [LANES-1:0]         check;
  logic                     shift_tick;
  logic                     hit;
  logic [LANES-1:0]         hit_lane;
  logic                     miss;
  logic [LANES-1:0]         miss_lane;
  logic                     wrong;
  logic [CNT_W-1:0]         hit_count;
  logic [CNT_W-1:0]         miss_count;

  modport master (
    output start, speed, data, buttons,
    input  out, check, shift_tick, hit, hit_lane, miss, miss_lane, wrong, hit_count, miss_count
  );

  modport slave (
    input  start, speed, data, buttons,
    output out, check, shift_tick, hit, hit_lane, miss, miss_lane, wrong, hit_count, miss_count
  );
endinterface

// File: rtl/note_scroller.sv
// Scrolls a LANES x ROWS note field one row per programmable tick and judges button
// presses against the bottom row, producing hit/miss/wrong pulses and saturating counters.
module note_scroller #(
  parameter int LANES    = 4,
  parameter int ROWS     = 10,
  parameter int TICK_DIV = 35000000,
  parameter int CNT_W    = 16
) (
  input logic           clk,
  input logic           reset,
  note_scroller_if.slave io
);
  localparam int FW = LANES * ROWS;
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]    field_q, field_d;
  logic [LANES-1:0] btn_q;
  logic             shift_q, shift_d;
  logic             hit_q, hit_d;
  logic [LANES-1:0] hit_lane_q, hit_lane_d;
  logic             miss_q, miss_d;
  logic [LANES-1:0] miss_lane_q, miss_lane_d;
  logic             wrong_q, wrong_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic [TW-1:0]    period;
  logic [LANES-1:0] press, row0, h, w, m;
  logic             active, tick;

  // Sum is kept 4 bits wider so even tiny CNT_W cannot wrap before the clamp.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LANES-1:0] v);
    logic [CNT_W+3:0] s;
    s = {4'b0, a} + (CNT_W+4)'($countones(v));
    return (s > {4'b0, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  assign row0   = field_q[LANES-1:0];
  assign press  = io.buttons & ~btn_q;
  assign h      = press & row0;
  assign w      = press & ~row0;
  assign period = TW'(TICK_DIV >> io.speed);
  assign active = (state_q == RUN) && io.start;
  assign tick   = active && (cnt_q >= period - TW'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    field_d      = field_q;
    shift_d      = 1'b0;
    hit_d        = 1'b0;
    hit_lane_d   = '0;
    miss_d       = 1'b0;
    miss_lane_d  = '0;
    wrong_d      = 1'b0;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    m            = '0;

    case (state_q)
      IDLE:    if (io.start)  state_d = RUN;
      RUN:     if (!io.start) state_d = PAUSE;
      PAUSE:   if (io.start)  state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (active) begin
      hit_d       = |h;
      hit_lane_d  = h;
      wrong_d     = |w;
      hit_count_d = sat_add(hit_count_q, h);
      // On a tick the judged row leaves the field, so unstruck notes become misses.
      if (tick) begin
        m            = row0 & ~press;
        field_d      = {io.data, field_q[FW-1:LANES]};
        cnt_d        = '0;
        shift_d      = 1'b1;
        miss_d       = |m;
        miss_lane_d  = m;
        miss_count_d = sat_add(miss_count_q, m);
      end else begin
        field_d[LANES-1:0] = row0 & ~h;
        cnt_d              = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      field_q      <= '0;
      btn_q        <= io.buttons;
      shift_q      <= 1'b0;
      hit_q        <= 1'b0;
      hit_lane_q   <= '0;
      miss_q       <= 1'b0;
      miss_lane_q  <= '0;
      wrong_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      field_q      <= field_d;
      btn_q        <= io.buttons;
      shift_q      <= shift_d;
      hit_q        <= hit_d;
      hit_lane_q   <= hit_lane_d;
      miss_q       <= miss_d;
      miss_lane_q  <= miss_lane_d;
      wrong_q      <= wrong_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign io.out        = field_q;
  assign io.check      = field_q[LANES-1:0];
  assign io.shift_tick = shift_q;
  assign io.hit        = hit_q;
  assign io.hit_lane   = hit_lane_q;
  assign io.miss       = miss_q;
  assign io.miss_lane  = miss_lane_q;
  assign io.wrong      = wrong_q;
  assign io.hit_count  = hit_count_q;
  assign io.miss_count = miss_count_q;
endmodule

// File: tb/tb_note_scroller.sv
// Self-checking bench for note_scroller: directed vector table, hand-written corner sequences,
// then randomized stimulus, every cycle compared against a row-array reference model.
module tb_note_scroller;
  localparam int LANES    = 4;
  localparam int ROWS     = 10;
  localparam int TICK_DIV = 8;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int MODE_IDLE  = 0;
  localparam int MODE_RUN   = 1;
  localparam int MODE_PAUSE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  note_scroller_if #(.LANES(LANES), .ROWS(ROWS), .CNT_W(CNT_W)) bus ();

  note_scroller #(.LANES(LANES), .ROWS(ROWS), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [LANES-1:0] mRows [ROWS];
  logic [LANES-1:0] mPrev;
  int               mCnt, mMode, mHits, mMisses;
  logic             eShift, eHit, eMiss, eWrong;
  logic [LANES-1:0] eHitLane, eMissLane;

  typedef struct {
    logic             rst;
    logic             st;
    logic [1:0]       spd;
    logic [LANES-1:0] dat;
    logic [LANES-1:0] btn;
    int               n;
    bit               chk;
    logic             xShift;
    logic             xHit;
    logic [LANES-1:0] xHitLane;
    logic             xMiss;
    logic [LANES-1:0] xMissLane;
    logic             xWrong;
    logic [LANES-1:0] xCheck;
    int               xHitCnt;
    int               xMissCnt;
  } vec_t;

  vec_t vecs [12];

  function automatic int satAdd(input int a, input int n);
    return (a + n > CNT_MAX) ? CNT_MAX : a + n;
  endfunction

  function automatic logic [LANES*ROWS-1:0] expOut();
    logic [LANES*ROWS-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*LANES +: LANES] = mRows[r];
    return v;
  endfunction

  // Reference: rows as an array, one behavioural step per clock edge using the pre-edge inputs.
  task automatic modelStep();
    int               period;
    logic [LANES-1:0] press, h, m;
    eShift = 1'b0; eHit = 1'b0; eMiss = 1'b0; eWrong = 1'b0;
    eHitLane = '0; eMissLane = '0;
    if (reset) begin
      for (int r = 0; r < ROWS; r++) mRows[r] = '0;
      mCnt = 0; mMode = MODE_IDLE; mHits = 0; mMisses = 0;
      mPrev = bus.buttons;
    end else begin
      press = bus.buttons & ~mPrev;
      mPrev = bus.buttons;
      if (mMode == MODE_RUN && bus.start) begin
        period   = TICK_DIV >> bus.speed;
        h        = press & mRows[0];
        eHit     = |h;
        eHitLane = h;
        eWrong   = |(press & ~mRows[0]);
        mHits    = satAdd(mHits, $countones(h));
        if (mCnt >= period - 1) begin
          m         = mRows[0] & ~press;
          eMiss     = |m;
          eMissLane = m;
          mMisses   = satAdd(mMisses, $countones(m));
          for (int r = 0; r < ROWS - 1; r++) mRows[r] = mRows[r+1];
          mRows[ROWS-1] = bus.data;
          mCnt   = 0;
          eShift = 1'b1;
        end else begin
          mRows[0] = mRows[0] & ~h;
          mCnt++;
        end
      end
      if (mMode == MODE_RUN) begin
        if (!bus.start) mMode = MODE_PAUSE;
      end else if (bus.start) begin
        mMode = MODE_RUN;
      end
    end
  endtask

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkField("out",        64'(bus.out),        64'(expOut()));
    checkField("check",      64'(bus.check),      64'(mRows[0]));
    checkField("shift_tick", 64'(bus.shift_tick), 64'(eShift));
    checkField("hit",        64'(bus.hit),        64'(eHit));
    checkField("hit_lane",   64'(bus.hit_lane),   64'(eHitLane));
    checkField("miss",       64'(bus.miss),       64'(eMiss));
    checkField("miss_lane",  64'(bus.miss_lane),  64'(eMissLane));
    checkField("wrong",      64'(bus.wrong),      64'(eWrong));
    checkField("hit_count",  64'(bus.hit_count),  64'(mHits));
    checkField("miss_count", 64'(bus.miss_count), 64'(mMisses));
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic [1:0] spd,
                               input logic [LANES-1:0] dat, input logic [LANES-1:0] btn);
    reset       = rst;
    bus.start   = st;
    bus.speed   = spd;
    bus.data    = dat;
    bus.buttons = btn;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    logic [LANES-1:0] btnR;
    logic             sawPulse;
    reset = 1'b1; bus.start = 1'b0; bus.speed = 2'd0; bus.data = '0; bus.buttons = '0;

    // rst st spd dat btn n chk | shift hit hitLane miss missLane wrong check hitCnt missCnt
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 2,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 9,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 7,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 1,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 64, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 3,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001, 1,  1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001, 4,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 1, 0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 1,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, 0};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0100, 1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001, 1, 0};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0100, 5,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 1, 0};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 4'b0001, 4'b0100, 1,  1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, 1, 1};

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].spd, vecs[i].dat, vecs[i].btn);
      if (vecs[i].chk) begin
        checkField($sformatf("vec%0d.shift", i),    64'(bus.shift_tick), 64'(vecs[i].xShift));
        checkField($sformatf("vec%0d.hit", i),      64'(bus.hit),        64'(vecs[i].xHit));
        checkField($sformatf("vec%0d.hitLane", i),  64'(bus.hit_lane),   64'(vecs[i].xHitLane));
        checkField($sformatf("vec%0d.miss", i),     64'(bus.miss),       64'(vecs[i].xMiss));
        checkField($sformatf("vec%0d.missLane", i), 64'(bus.miss_lane),  64'(vecs[i].xMissLane));
        checkField($sformatf("vec%0d.wrong", i),    64'(bus.wrong),      64'(vecs[i].xWrong));
        checkField($sformatf("vec%0d.check", i),    64'(bus.check),      64'(vecs[i].xCheck));
        checkField($sformatf("vec%0d.hitCnt", i),   64'(bus.hit_count),  64'(vecs[i].xHitCnt));
        checkField($sformatf("vec%0d.missCnt", i),  64'(bus.miss_count), 64'(vecs[i].xMissCnt));
      end
    end

    // Press landing exactly on the tick with row0 = 0011: hit and miss in the same cycle.
    repeat (2) applyStimulus(1'b1, 1'b0, 2'd0, 4'b0011, 4'b0000);
    repeat (1 + 8 + 72) applyStimulus(1'b0, 1'b1, 2'd0, 4'b0011, 4'b0000);
    checkField("tickPress.row0", 64'(bus.check), 64'(4'b0011));
    repeat (7) applyStimulus(1'b0, 1'b1, 2'd0, 4'b0011, 4'b0000);
    applyStimulus(1'b0, 1'b1, 2'd0, 4'b0011, 4'b0001);
    checkField("tickPress.shift",    64'(bus.shift_tick), 64'(1'b1));
    checkField("tickPress.hitLane",  64'(bus.hit_lane),   64'(4'b0001));
    checkField("tickPress.missLane", 64'(bus.miss_lane),  64'(4'b0010));

    // Pause with three counts elapsed; resume needs one re-entry cycle plus five counts.
    repeat (3) applyStimulus(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
    sawPulse = 1'b0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 4'b0000, (k == 10) ? 4'b1111 : 4'b0000);
      sawPulse = sawPulse | bus.shift_tick | bus.hit | bus.miss | bus.wrong;
    end
    checkField("pause.noPulses", 64'(sawPulse), 64'(1'b0));
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000);
      checkField($sformatf("resume.shift%0d", k), 64'(bus.shift_tick), 64'(k == 5));
    end

    // Speed jump to x8 with cnt = 5 ticks at once and every cycle after; then reset mid-run.
    repeat (5) applyStimulus(1'b0, 1'b1, 2'd0, 4'b1010, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 2'd3, 4'b1010, 4'b0000);
      checkField($sformatf("speed3.shift%0d", k), 64'(bus.shift_tick), 64'(1'b1));
    end
    applyStimulus(1'b1, 1'b1, 2'd3, 4'b1010, 4'b0000);
    checkField("midReset.out",     64'(bus.out),        64'(0));
    checkField("midReset.hitCnt",  64'(bus.hit_count),  64'(0));
    checkField("midReset.missCnt", 64'(bus.miss_count), 64'(0));
    applyStimulus(1'b0, 1'b1, 2'd3, 4'b1010, 4'b0000);
    checkField("midReset.idle", 64'(bus.shift_tick), 64'(1'b0));

    // Random run: mostly running, slow button toggling, occasional reset; counters saturate.
    btnR = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < LANES; b++)
        if ($urandom_range(7, 0) == 0) btnR[b] = ~btnR[b];
      applyStimulus(($urandom_range(299, 0) == 0), ($urandom_range(15, 0) != 0),
                    2'($urandom_range(3, 0)), LANES'($urandom_range(15, 0)), btnR);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Parametrised successor of the note-field shifter for the rhythm game. It scrolls a LANES x ROWS note field one row per tick. The tick period is programmable and speed-selectable.
- It also performs the hit/miss judgement at the bottom row, replacing the external compare-with-enable scheme. It drives the colour module through `out` and the scoring logic through the hit/miss pulses and saturating counters.

Parameters:
- LANES, 4, number of note lanes (buttons); 1..8.
- ROWS, 10, number of visible rows; row 0 is the bottom (judgement) row, row ROWS-1 is the entry row; 2..32.
- TICK_DIV, 35000000, clk cycles per scroll tick at speed 0; must be >= 8.
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, level: 1 = run, 0 = pause.
- speed, input, 2, period = TICK_DIV >> speed (x1, x2, x4, x8 scroll rate).
- data, input, LANES, note pattern entering row ROWS-1 on each tick.
- buttons, input, LANES, debounced button levels, 1 = pressed.
- out, output, LANES*ROWS, note field; bits [r*LANES +: LANES] = row r.
- check, output, LANES, row 0 (equal to out[LANES-1:0]).
- shift_tick, output, 1, 1-cycle pulse coincident with a new field value.
- hit, output, 1, 1-cycle pulse: at least one note struck.
- hit_lane, output, LANES, lanes struck, valid while hit = 1, else 0.
- miss, output, 1, 1-cycle pulse: at least one note left row 0 unstruck.
- miss_lane, output, LANES, lanes missed, valid while miss = 1, else 0.
- wrong, output, 1, 1-cycle pulse: a press in a lane with no note in row 0.
- hit_count, output, CNT_W, saturating count of struck notes (per lane bit).
- miss_count, output, CNT_W, saturating count of missed notes (per lane bit).

Behaviour:
- All outputs are registered.
- reset (any state, any cycle) has priority over everything. It gives:
  - state = IDLE; field and tick counter = 0.
  - All pulses, lane vectors and counters = 0.
  - Button edge register is loaded with the current buttons value, so held buttons do not produce presses.
- FSM:
  - IDLE: field frozen at 0; start = 1 -> RUN.
  - RUN: start = 0 -> PAUSE.
  - PAUSE: field and tick counter held, no pulses; start = 1 -> RUN, resuming the counter from its held value.
- Tick counter (RUN only):
  - period P = TICK_DIV >> speed.
  - Tick condition is cnt >= P-1. On a tick, cnt <= 0; otherwise cnt <= cnt + 1.
  - Lowering the period mid-count therefore ticks on the next RUN cycle.
  - The first tick occurs P cycles after entering RUN from IDLE.
- Press detect: press = buttons & ~buttons_q, evaluated every cycle; buttons_q always updates. A press is judged only in RUN, otherwise it is ignored.
- Non-tick RUN cycle:
  - h = press & row0; w = press & ~row0.
  - row0 <= row0 & ~h.
  - hit = |h, hit_lane = h; wrong = |w.
- Tick cycle (RUN):
  - h = press & row0; m = row0 & ~press.
  - Row r <= row r+1 for r < ROWS-1; row ROWS-1 <= data.
  - shift_tick = 1; hit/hit_lane from h; miss = |m, miss_lane = m; wrong = |(press & ~row0).
  - Press judgement uses the pre-shift row 0.
- Pulse timing: pulses are high for exactly the one cycle following the deciding edge. shift_tick is aligned with the updated `out`.
- Counters:
  - hit_count += popcount(h); miss_count += popcount(m).
  - Each saturates at 2^CNT_W - 1 with no wrap.
  - Held through PAUSE; cleared only by reset.
- A stopped start (PAUSE) does not clear the field; only reset clears it.

Test Plan:
- TICK_DIV=8, speed=0, LANES=4, ROWS=10. Reset, start=1, data=4'b0001 constant. Required:
  - shift_tick every 8 cycles.
  - After 10 ticks, check = 4'b0001.
  - Tick 11: miss = 1, miss_lane = 4'b0001, miss_count = 1.
- Note in row 0 lane 0: press button 0 mid-period -> next cycle hit = 1, hit_lane = 4'b0001, check = 0, hit_count = 1. The following tick gives no miss for that note.
- Press button 2 with row0 = 4'b0001 -> wrong = 1; hit = 0; row 0 unchanged. Holding the button for 20 cycles gives no repeat press.
- Press on exactly the tick cycle with row0 = 4'b0011, press = 4'b0001. Required: hit_lane = 4'b0001, miss_lane = 4'b0010, shift_tick = 1, all in the same cycle.
- start=0 for 30 cycles mid-run -> out, counters and cnt frozen; no pulses. On start=1 the next tick arrives after the remaining count.
- speed 0 -> 3 with cnt = 5 (P = 1) -> tick on the next cycle, then every 1 cycle. Reset asserted mid-tick -> next cycle out = 0, counters = 0, IDLE.
